aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Iterative AES-128 encryption sequencer. It accepts one 128-bit plaintext block and fetches round keys one at a time from an external key schedule. It runs the round datapath (subBytes -> shiftRows -> mixColumns -> addRoundKey) once per round through its own state register, then presents the ciphertext. It sits between the host-side block stream and the key-expansion unit and is the only owner of the round state.

## Interface
- NR, 10: number of rounds. The final round skips mixColumns.
- RW, 4: width of the round index. It must hold NR.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  plaintext offered
- in_ready  out  1  controller can accept a block
- in_data  in  128  plaintext. Bits [127:120] are byte 0, column-major.
- rk_req  out  1  round key requested
- rk_idx  out  RW  index of the requested round key, 0..NR
- rk_valid  in  1  rk_data holds key rk_idx
- rk_data  in  128  round key
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer takes ciphertext
- out_data  out  128  ciphertext, same byte order as in_data
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, LOAD, ROUND, DONE.
- IDLE
  - in_ready=1.
  - When in_valid && in_ready: capture in_data into the plaintext register, set rk_idx=0, go to LOAD.
- LOAD
  - rk_req=1, rk_idx=0.
  - When rk_valid: state <= plaintext ^ rk_data, rk_idx <= 1, go to ROUND.
- ROUND
  - rk_req=1, rk_idx=r.
  - When rk_valid: state <= round_fn(state, rk_data, final = (r==NR)).
  - If r==NR: go to DONE. Otherwise r <= r+1.
- DONE
  - out_valid=1, out_data=state.
  - When out_ready: go to IDLE.
- Request rules
  - rk_req and rk_idx stay stable until rk_valid is sampled high.
  - rk_valid while rk_req=0 is ignored.
  - rk_valid may stay high continuously.
- Input port: in_valid is ignored outside IDLE.
- Output port: out_data stays stable while out_valid && !out_ready.
- Width rules
  - rk_idx never exceeds NR.
  - The index increments only on a round that is not final, so it does not wrap.

## Timing
- Reset values (asynchronous, effective immediately):
  - FSM=IDLE, in_ready=1, rk_req=0, rk_idx=0.
  - out_valid=0, out_data=0, busy=0.
  - state and plaintext registers = 0.
- Reset mid-operation: the block is dropped silently and no output is produced. The first cycle after deassertion is IDLE.
- Latency with rk_valid tied high:
  - Accept edge E0.
  - State is loaded at E1.
  - Rounds 1..NR complete at E2..E(NR+1).
  - out_valid rises after E(NR+1), i.e. NR+1 cycles after acceptance (11 for NR=10).
- Each cycle of rk_valid=0 in LOAD or ROUND adds exactly one cycle.
- Output handshake
  - The out_valid && out_ready edge returns the FSM to IDLE.
  - in_ready rises the following cycle; there is no same-cycle accept.
  - Minimum block-to-block period is NR+3 cycles.
- Round datapath: purely combinational, evaluated in the single cycle of the round-key handshake.

## Structure
- Shared package aes_pkg:
  - AES_W=128, NR_AES128=10
  - FSM state encodings ST_IDLE, ST_LOAD, ST_ROUND, ST_DONE
  - byte-order convention (byte 0 = MSB)
- Sub-module aes_round_fn: combinational subBytes -> shiftRows -> optional mixColumns (bypassed when final=1) -> XOR with rk_data.
- The controller holds only the FSM, the round counter, and the plaintext and state registers.

## Test plan
The bench models a key-schedule responder for every scenario.

- FIPS-197 B, back-to-back flow:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, rk_valid tied 1, out_ready=1.
  - Required: out_data=3925841d02dc09fbdc118597196a0b32; out_valid 11 cycles after accept; rk_idx sequence 0..10.
- FIPS-197 C.1 with stalls:
  - Stimulus: key 000102..0f, pt 00112233445566778899aabbccddeeff, random rk_valid gaps.
  - Required: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a; latency = 11 + number of stall cycles; rk_idx stable during stalls.
- Output backpressure:
  - Stimulus: out_ready held 0 for 5 cycles after out_valid.
  - Required: out_data constant; in_ready=0; a second in_valid is not accepted until the cycle after the out handshake.
- Spurious key and input strobes:
  - Stimulus: rk_valid pulsed in IDLE and DONE; in_valid pulsed during ROUND.
  - Required: no change to state, rk_idx or ciphertext.
- Reset mid-round:
  - Stimulus: rst asserted during round 5.
  - Required: all outputs take their reset values immediately. The next block then encrypts correctly (FIPS-197 B vector).
- Consecutive blocks:
  - Stimulus: B vector then C.1 vector with continuous in_valid.
  - Required: both ciphertexts correct; period 13 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte helpers for the round controller and datapath.
// Latency: none; this file holds only declarations and pure functions.
// Backpressure: not applicable.
package aes_pkg;

    localparam int AES_W     = 128;
    localparam int NR_AES128 = 10;
    localparam int AES_BYTES = AES_W / 8;

    // Controller FSM encodings
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } aes_state_e;

    // Forward S-box, entry 0 in the most significant byte
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte 0 is the most significant byte; bytes run down the columns
    function automatic logic [7:0] get_byte(input logic [AES_W-1:0] blk, input int idx);
        return blk[AES_W-1-8*idx -: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_round_fn.sv
// One AES round: subBytes -> shiftRows -> mixColumns (skipped on the final round) -> addRoundKey.
// Latency: purely combinational, settles within the round-key handshake cycle.
// Backpressure: none; the caller decides when to register the result.
module aes_round_fn
    import aes_pkg::*;
(
    input  logic [AES_W-1:0] state_in,
    input  logic [AES_W-1:0] rk_data,
    input  logic             final_rnd,
    output logic [AES_W-1:0] state_out
);

    logic [7:0] sb_b [AES_BYTES];
    logic [7:0] sr_b [AES_BYTES];
    logic [7:0] mc_b [AES_BYTES];

    // Byte-wise S-box substitution
    always_comb begin
        for (int i = 0; i < AES_BYTES; i++) begin
            sb_b[i] = sub_byte(get_byte(state_in, i));
        end
    end

    // Row r of the column-major state rotates left by r columns
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_b[4*c+r] = sb_b[4*((c+r)%4)+r];
            end
        end
    end

    // Column mix with the fixed {02,03,01,01} circulant matrix
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc_b[4*c]   = xtime(sr_b[4*c])   ^ xtime(sr_b[4*c+1]) ^ sr_b[4*c+1]
                        ^ sr_b[4*c+2]        ^ sr_b[4*c+3];
            mc_b[4*c+1] = sr_b[4*c]          ^ xtime(sr_b[4*c+1]) ^ xtime(sr_b[4*c+2])
                        ^ sr_b[4*c+2]        ^ sr_b[4*c+3];
            mc_b[4*c+2] = sr_b[4*c]          ^ sr_b[4*c+1]        ^ xtime(sr_b[4*c+2])
                        ^ xtime(sr_b[4*c+3]) ^ sr_b[4*c+3];
            mc_b[4*c+3] = xtime(sr_b[4*c])   ^ sr_b[4*c]          ^ sr_b[4*c+1]
                        ^ sr_b[4*c+2]        ^ xtime(sr_b[4*c+3]);
        end
    end

    // Final round bypasses mixColumns, then every round adds the key
    always_comb begin
        state_out = '0;
        for (int i = 0; i < AES_BYTES; i++) begin
            state_out[AES_W-1-8*i -: 8] = (final_rnd ? sr_b[i] : mc_b[i]) ^ get_byte(rk_data, i);
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryptor: takes a block, pulls round keys 0..NR one per handshake, emits ciphertext.
// Latency: out_valid NR+1 cycles after accept, plus one cycle per cycle rk_valid is low while requesting.
// Backpressure: in_ready only in IDLE; ciphertext held stable until out_ready; key stalls just extend a round.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = NR_AES128,
    parameter int RW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [AES_W-1:0] in_data,
    output logic             rk_req,
    output logic [RW-1:0]    rk_idx,
    input  logic             rk_valid,
    input  logic [AES_W-1:0] rk_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AES_W-1:0] out_data,
    output logic             busy
);

    aes_state_e       fsm_q, fsm_d;
    logic [RW-1:0]    rnd_q, rnd_d;
    logic [AES_W-1:0] pt_q,  pt_d;
    logic [AES_W-1:0] st_q,  st_d;
    logic [AES_W-1:0] rnd_out;
    logic             last_rnd;

    // The counter stops at NR, so it never needs to wrap
    assign last_rnd = (rnd_q == RW'(NR));
    assign rk_idx   = rnd_q;

    aes_round_fn u_round_fn (
        .state_in  (st_q),
        .rk_data   (rk_data),
        .final_rnd (last_rnd),
        .state_out (rnd_out)
    );

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        fsm_d     = fsm_q;
        rnd_d     = rnd_q;
        pt_d      = pt_q;
        st_d      = st_q;
        in_ready  = 1'b0;
        rk_req    = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b1;
        case (fsm_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    pt_d  = in_data;
                    rnd_d = '0;
                    fsm_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                rk_req = 1'b1;
                if (rk_valid) begin
                    st_d  = pt_q ^ rk_data;
                    rnd_d = RW'(1);
                    fsm_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                rk_req = 1'b1;
                if (rk_valid) begin
                    st_d = rnd_out;
                    if (last_rnd) begin
                        fsm_d = ST_DONE;
                    end else begin
                        rnd_d = rnd_q + RW'(1);
                    end
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                out_data  = st_q;
                if (out_ready) begin
                    rnd_d = '0;
                    fsm_d = ST_IDLE;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset drops any block in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q <= ST_IDLE;
            rnd_q <= '0;
            pt_q  <= '0;
            st_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            rnd_q <= rnd_d;
            pt_q  <= pt_d;
            st_q  <= st_d;
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PTC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CTC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_valid = 1'b0;
    logic [127:0] rk_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int accept_cyc = 0;
    int hs_cyc     = 0;

    logic [7:0]   sb_tab [256];
    logic [127:0] rk_tab [0:10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Key-schedule responder: answers whatever index is requested
    assign rk_data = (int'(rk_idx) <= NR) ? rk_tab[int'(rk_idx)] : '0;

    aes_round_ctrl #(.NR(NR), .RW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_req    (rk_req),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_data   (rk_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from the field inverse (x^254) and the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                inv = 8'h01;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            end
            sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic key_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_tab[t[31:24]], sb_tab[t[23:16]], sb_tab[t[15:8]], sb_tab[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Textbook cipher over a 4x4 byte matrix m[row][col]
    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
        logic [7:0]   m [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] res;
        logic [127:0] k;
        k = rk_tab[0];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = pt[127-8*(4*c+r) -: 8] ^ k[127-8*(4*c+r) -: 8];
        for (int rnd = 1; rnd <= NR; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sb_tab[m[r][(c+r)%4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    if (rnd < NR)
                        m[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                                ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    else
                        m[r][c] = t[r][c];
            k = rk_tab[rnd];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    m[r][c] = m[r][c] ^ k[127-8*(4*c+r) -: 8];
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = m[r][c];
        return res;
    endfunction

    // ---------------- one block through the DUT ----------------
    task automatic do_block(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct_const,
                            input bit use_const, input bit stalls, input bit noise, input int hold_out,
                            input logic [127:0] next_pt, input bit keep_valid);
        logic [127:0] exp;
        logic [127:0] held;
        logic [3:0]   pend_idx;
        bit           pend;
        int           cnt, nstall, unstable, wait_n, bad;
        int           idxq[$];

        key_expand(key);
        exp = use_const ? ct_const : ref_encrypt(pt);
        out_ready = (hold_out == 0);
        rk_valid  = 1'b1;
        in_valid  = 1'b1;
        in_data   = pt;
        wait_n = 0;
        while (!in_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 128'(in_ready), 128'(1));
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        accept_cyc = cyc;
        chk("load_req", 128'({rk_req, rk_idx, busy}), 128'({1'b1, 4'd0, 1'b1}));
        if (keep_valid) in_data = next_pt;
        else            in_valid = 1'b0;

        cnt = 0; nstall = 0; unstable = 0; pend = 1'b0; pend_idx = '0;
        while (cnt < 400 && !out_valid) begin
            if (pend && rk_idx != pend_idx) unstable++;
            rk_valid = stalls ? ($urandom_range(0, 99) < 60) : 1'b1;
            if (noise && !keep_valid) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            if (rk_req) begin
                if (rk_valid) idxq.push_back(int'(rk_idx));
                else          nstall++;
            end
            pend     = rk_req && !rk_valid;
            pend_idx = rk_idx;
            @(negedge clk);
            cnt++;
        end
        if (!keep_valid) in_valid = 1'b0;
        rk_valid = 1'b1;
        if (!out_valid) begin
            chk("out_timeout", 128'(out_valid), 128'(1));
            return;
        end
        chk("latency", 128'(cnt), 128'(NR + 1 + nstall));
        chk("rk_idx_stable", 128'(unstable), 128'(0));
        bad = (idxq.size() == NR + 1) ? 0 : 1;
        foreach (idxq[i]) if (idxq[i] != i) bad++;
        chk("rk_idx_seq", 128'(bad), 128'(0));
        chk("ciphertext", out_data, exp);
        chk("done_flags", 128'({in_ready, rk_req, busy}), 128'({1'b0, 1'b0, 1'b1}));
        held = out_data;
        for (int h = 0; h < hold_out; h++) begin
            @(negedge clk);
            chk("hold_data", out_data, held);
            chk("hold_flags", 128'({out_valid, in_ready}), 128'({1'b1, 1'b0}));
        end
        out_ready = 1'b1;
        @(negedge clk);
        hs_cyc = cyc;
        chk("after_hs", 128'({out_valid, in_ready, busy, rk_req}), 128'({1'b0, 1'b1, 1'b0, 1'b0}));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(tag, 128'({in_ready, rk_req, rk_idx, out_valid, busy}), 128'({1'b1, 1'b0, 4'd0, 1'b0, 1'b0}));
        chk({tag, "_data"}, out_data, 128'h0);
    endtask

    task automatic reset_mid_round();
        int n;
        key_expand(KB);
        out_ready = 1'b1;
        rk_valid  = 1'b1;
        in_valid  = 1'b1;
        in_data   = PTB;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!(rk_req && rk_idx == 4'd5) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("reach_round5", 128'({rk_req, rk_idx}), 128'({1'b1, 4'd5}));
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid_round");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("rst_held");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_released");
    endtask

    initial begin
        logic [127:0] rp, rkey;
        int a1, hs;
        build_sbox();
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_state");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 B, keys always ready
        do_block(PTB, KB, CTB, 1, 0, 0, 0, '0, 0);
        // FIPS-197 C.1, random key gaps and junk strobes while busy
        do_block(PTC, KC, CTC, 1, 1, 1, 0, '0, 0);
        // Output backpressure with a second block waiting
        do_block(PTB, KB, CTB, 1, 0, 0, 5, PTC, 1);
        hs = hs_cyc;
        do_block(PTC, KC, CTC, 1, 0, 0, 0, '0, 0);
        chk("accept_after_hs", 128'(accept_cyc), 128'(hs + 1));
        // Reset in round 5, then a clean block
        reset_mid_round();
        do_block(PTB, KB, CTB, 1, 0, 0, 0, '0, 0);
        // Consecutive blocks with in_valid held high
        do_block(PTB, KB, CTB, 1, 0, 0, 0, PTC, 1);
        a1 = accept_cyc;
        do_block(PTC, KC, CTC, 1, 0, 0, 0, '0, 0);
        chk("period", 128'(accept_cyc - a1), 128'(NR + 3));
        // Random blocks against the model
        for (int k = 0; k < 6; k++) begin
            rp   = {$urandom, $urandom, $urandom, $urandom};
            rkey = {$urandom, $urandom, $urandom, $urandom};
            do_block(rp, rkey, '0, 0, 1, 1, $urandom_range(0, 3), '0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "simulation did not finish");
    end

endmodule
